// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: op encoding and chunk-size helpers for the
// pipelined adder/subtractor.
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit chunk_legal(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; one instance per pipeline stage.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready flow control with bubble collapse.
module pipelined_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!chunk_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0]             v, en, v_in, c_in, c_r, co;
  logic [STAGES-1:0][WIDTH-1:0]  a_r, b_r, s_r;
  logic [STAGES-1:0][WIDTH-1:0]  a_in, b_in, s_in, s_next;
  logic [STAGES-1:0][CHUNK-1:0]  s_chunk;
  logic                          ovf_r, zero_r, ovf_next, zero_next;

  // Stage k consumes either the port operands (k=0) or stage k-1 registers.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = '0;
    v_in = '0;
    a_in[0] = a;
    b_in[0] = (sub == OP_SUB) ? ~b : b;
    c_in[0] = (sub == OP_SUB) ? ~cin : cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = c_r[k-1];
      v_in[k] = v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a  (a_in[k][k*CHUNK +: CHUNK]),
      .b  (b_in[k][k*CHUNK +: CHUNK]),
      .ci (c_in[k]),
      .s  (s_chunk[k]),
      .co (co[k])
    );
  end

  always_comb begin
    s_next = s_in;
    for (int k = 0; k < STAGES; k++) begin
      s_next[k][k*CHUNK +: CHUNK] = s_chunk[k];
    end
  end

  // A stage may load when empty or when its successor is loading this cycle.
  always_comb begin
    en       = '0;
    en[LAST] = !v[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      en[k] = !v[k] || en[k+1];
    end
  end

  assign ovf_next  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                     (s_next[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  assign zero_next = ~|s_next[LAST];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so outputs read zero after reset rather than stale operands.
      v      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      c_r    <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v[k] <= v_in[k];
          if (v_in[k]) begin
            a_r[k] <= a_in[k];
            b_r[k] <= b_in[k];
            s_r[k] <= s_next[k];
            c_r[k] <= co[k];
          end
        end
      end
      if (en[LAST] && v_in[LAST]) begin
        ovf_r  <= ovf_next;
        zero_r <= zero_next;
      end
    end
  end

  // Operand copies in the last stage and low chunks already summed are never read again.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a_r, b_r};

  assign in_ready  = en[0];
  assign out_valid = v[LAST];
  assign sum       = s_r[LAST];
  assign cout      = c_r[LAST];
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: W16/S2 main instance plus W32/S4 and W16/S1
// instances for carry propagation and single-stage latency.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // W16 / S2
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;
  // W32 / S4
  logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf, w_zero;
  logic [31:0] w_a, w_b, w_sum;
  // W16 / S1
  logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf, s_zero;
  logic [15:0] s_a, s_b, s_sum;

  pipelined_addsub #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
    .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
  );

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum),
    .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
  );

  // Stream vectors: {a, b, cin, sub}
  logic [15:0] va   [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'hABCD, 16'h00FF, 16'h4000};
  logic [15:0] vb   [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h7FFF, 16'h0000, 16'h5433, 16'h0001, 16'hC000};
  logic        vcin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        vsub [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ovf, zero, cout, sum}.
  function automatic logic [18:0] model(input logic [15:0] ma, mb, input logic mcin, msub);
    logic [15:0] be;
    logic        ce;
    logic [16:0] r;
    be = msub ? ~mb : mb;
    ce = msub ? ~mcin : mcin;
    r  = {1'b0, ma} + {1'b0, be} + {16'b0, ce};
    return {(ma[15] == be[15]) && (r[15] != ma[15]), r[15:0] == 16'h0, r[16], r[15:0]};
  endfunction

  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tcin, input logic tsub,
                      input logic [15:0] esum, input logic ec, input logic eo, input logic ez);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    check({tag, "_lat1"}, out_valid, 1'b0);
    step();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"},   sum,  esum);
    check({tag, "_cout"},  cout, ec);
    check({tag, "_ovf"},   ovf,  eo);
    check({tag, "_zero"},  zero, ez);
  endtask

  task automatic run_stream(input bit use_pattern, output int cycles);
    logic [18:0] q[$];
    logic [18:0] held;
    bit          held_valid;
    int          sent, got;
    sent = 0; got = 0; cycles = 0; held_valid = 1'b0; held = '0;
    while (got < 8 && cycles < 60) begin
      out_ready = use_pattern ? pat[cycles % 4] : 1'b1;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; cin = vcin[sent]; sub = vsub[sent];
      end
      #4;
      if (out_valid) begin
        if (held_valid) check("stall_hold", {13'b0, ovf, zero, cout, sum}, {13'b0, held});
        if (out_ready) begin
          if (q.size() == 0) check("stream_extra", 1, 0);
          else check("stream_result", {13'b0, ovf, zero, cout, sum}, {13'b0, q.pop_front()});
          got++;
          held_valid = 1'b0;
        end else begin
          held_valid = 1'b1;
          held = {ovf, zero, cout, sum};
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(va[sent], vb[sent], vcin[sent], vsub[sent]));
        sent++;
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, 8);
    check("stream_drained", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    repeat (2) step();

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum",       sum,  16'h0000);
    check("rst_cout",      cout, 1'b0);
    check("rst_ovf",       ovf,  1'b0);
    check("rst_zero",      zero, 1'b0);
    check("rst_w32_zero",  w_zero, 1'b0);
    check("rst_s1_valid",  s_out_valid, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  in_ready, 1'b1);

    op16("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op16("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op16("add_cin",    16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
    op16("sub_borrow", 16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    check("idle_after_ops", out_valid, 1'b0);

    run_stream(1'b1, cyc);
    run_stream(1'b0, cyc);
    check("throughput_cycles", cyc, 10);

    // Reset with two operations in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    step();
    a = 16'h2222; b = 16'h2222;
    step();
    check("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready",  in_ready,  1'b1);
    check("midrst_sum",       sum, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst_no_stale", out_valid, 1'b0);
    end

    // W32/S4: carry ripples through all four chunks.
    w_a = 32'hFFFF_FFFF; w_b = 32'h0; w_cin = 1'b1; w_sub = 1'b0; w_in_valid = 1'b1;
    step();
    w_in_valid = 1'b0;
    step();
    step();
    check("w32_lat3", w_out_valid, 1'b0);
    step();
    check("w32_valid", w_out_valid, 1'b1);
    check("w32_sum",   w_sum,  32'h0);
    check("w32_cout",  w_cout, 1'b1);
    check("w32_zero",  w_zero, 1'b1);
    check("w32_ovf",   w_ovf,  1'b0);

    // W16/S1: single registered stage.
    s_a = 16'hFFFF; s_b = 16'h0; s_cin = 1'b1; s_sub = 1'b0; s_in_valid = 1'b1;
    step();
    check("s1_valid", s_out_valid, 1'b1);
    check("s1_sum",   s_sum,  16'h0000);
    check("s1_cout",  s_cout, 1'b1);
    check("s1_zero",  s_zero, 1'b1);
    s_a = 16'h8000; s_b = 16'h0001; s_cin = 1'b0; s_sub = 1'b1;
    step();
    s_in_valid = 1'b0;
    check("s1_sub_sum", s_sum, 16'h7FFF);
    check("s1_sub_ovf", s_ovf, 1'b1);
    check("s1_sub_cout", s_cout, 1'b1);
    step();
    check("s1_drained", s_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
